// File: rtl/booth_mul_pkg.sv
// Shared Booth digit type and elaboration-time helpers for booth_mul_pipe.
package booth_mul_pkg;

   typedef enum logic [2:0] {
      ZERO = 3'd0,
      P1   = 3'd1,
      P2   = 3'd2,
      M1   = 3'd3,
      M2   = 3'd4
   } booth_digit_e;

   function automatic int unsigned booth_digits(input int unsigned width);
      return width / 2 + 1;
   endfunction

   // Dadda row-height sequence: d(0)=2, d(j+1)=floor(1.5*d(j)) -> 2,3,4,6,9,13,...
   function automatic int unsigned dadda_height(input int unsigned idx);
      int unsigned h;
      h = 2;
      for (int unsigned j = 0; j < idx; j++) h = (h * 3) / 2;
      return h;
   endfunction

   // Number of reduction stages needed to bring 'rows' down to two.
   function automatic int unsigned dadda_stages(input int unsigned rows);
      int unsigned n;
      n = 0;
      for (int unsigned j = 0; j < 32; j++)
         if (dadda_height(j) < rows) n = j + 1;
      return n;
   endfunction

endpackage

// File: rtl/booth_enc.sv
// Radix-4 Booth recoder: one overlapping 3-bit multiplier window to a signed digit.
module booth_enc
   import booth_mul_pkg::*;
(
   input  logic [2:0] i_win,
   output logic [2:0] o_digit_c
);

   always_comb begin
      o_digit_c = ZERO;
      unique case (i_win)
         3'b001, 3'b010: o_digit_c = P1;
         3'b011:         o_digit_c = P2;
         3'b100:         o_digit_c = M2;
         3'b101, 3'b110: o_digit_c = M1;
         default:        o_digit_c = ZERO;
      endcase
   end

endmodule

// File: rtl/booth_mul_pipe.sv
// 3-stage radix-4 Booth / Dadda multiplier with valid/ready handshake.
// Define BOOTH_MUL_MAC_EN to add the in_acc port and a running accumulator.
module booth_mul_pipe
   import booth_mul_pkg::*;
#(
   parameter int unsigned WIDTH = 12,
   parameter int unsigned OUT_W = 2 * WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_signed,
`ifdef BOOTH_MUL_MAC_EN
   input  logic             in_acc,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_p
);

   localparam int unsigned EXT_W  = WIDTH + 2;
   localparam int unsigned N_DIG  = booth_digits(WIDTH);
   localparam int unsigned N_ROWS = N_DIG + 1;
   localparam int unsigned N_STG  = dadda_stages(N_ROWS);

   // Folded sign-extension constant: -2^(EXT_W-1+2i) summed over all digit rows.
   function automatic logic [OUT_W-1:0] sext_const();
      logic [OUT_W-1:0] k;
      k = '0;
      for (int unsigned i = 0; i < N_DIG; i++)
         k = k - (OUT_W'(1) << (EXT_W - 1 + 2 * i));
      return k;
   endfunction
   localparam logic [OUT_W-1:0] SEXT_K = sext_const();

   logic             w_stall;
   logic             r_v1, r_v2, r_v3;
   logic [WIDTH-1:0] r_a1, r_b1;
   logic             r_sgn1;
   logic [OUT_W-1:0] r_s2, r_c2, r_p;
   logic [EXT_W-1:0] w_a_ext;
   logic [EXT_W:0]   w_b_win;
   logic [N_DIG-1:0] w_neg;
   logic [OUT_W-1:0] w_row [N_ROWS];
   logic [OUT_W-1:0] w_sum2, w_car2, w_p3;

   assign w_stall   = r_v3 & ~out_ready;
   assign in_ready  = ~w_stall;
   assign out_valid = r_v3;
   assign out_p     = r_p;

   assign w_a_ext = {{2{r_sgn1 & r_a1[WIDTH-1]}}, r_a1};
   assign w_b_win = {{2{r_sgn1 & r_b1[WIDTH-1]}}, r_b1, 1'b0};

   // Partial products: one's-complement row with inverted sign bit; the +1 of
   // each negative digit rides in the empty low bits of the next row.
   for (genvar i = 0; i < N_DIG; i++) begin : g_dig
      logic [2:0]       w_code;
      logic [EXT_W-1:0] w_mag;
      logic [EXT_W-1:0] w_pp;
      logic             w_ng;

      booth_enc u_enc (
         .i_win     (w_b_win[2*i+2 -: 3]),
         .o_digit_c (w_code)
      );

      always_comb begin
         w_mag = '0;
         w_ng  = 1'b0;
         unique case (booth_digit_e'(w_code))
            P1:      w_mag = w_a_ext;
            P2:      w_mag = w_a_ext << 1;
            M1:      begin w_mag = w_a_ext;      w_ng = 1'b1; end
            M2:      begin w_mag = w_a_ext << 1; w_ng = 1'b1; end
            default: w_mag = '0;
         endcase
         w_pp = w_ng ? ~w_mag : w_mag;
      end

      assign w_neg[i] = w_ng;

      if (i == 0) begin : g_first
         assign w_row[i] = OUT_W'({~w_pp[EXT_W-1], w_pp[EXT_W-2:0]});
      end else begin : g_rest
         assign w_row[i] = (OUT_W'({~w_pp[EXT_W-1], w_pp[EXT_W-2:0]}) << (2 * i))
                         | (OUT_W'(w_neg[i-1]) << (2 * i - 2));
      end
   end

   // Last digit's +1 lands below the constant's lowest set bit, so OR is exact.
   assign w_row[N_DIG] = SEXT_K | (OUT_W'(w_neg[N_DIG-1]) << (2 * (N_DIG - 1)));

   // Dadda reduction: each stage applies just enough 3:2 row compressors to hit the next height.
   for (genvar s = 0; s < N_STG; s++) begin : g_stg
      localparam int unsigned N_IN  = (s == 0) ? N_ROWS : dadda_height(N_STG - s);
      localparam int unsigned N_OUT = dadda_height(N_STG - 1 - s);
      localparam int unsigned N_CSA = N_IN - N_OUT;

      logic [OUT_W-1:0] w_in  [N_IN];
      logic [OUT_W-1:0] w_out [N_OUT];

      for (genvar r = 0; r < N_IN; r++) begin : g_src
         if (s == 0) begin : g_pp
            assign w_in[r] = w_row[r];
         end else begin : g_prev
            assign w_in[r] = g_stg[s-1].w_out[r];
         end
      end

      for (genvar c = 0; c < N_CSA; c++) begin : g_csa
         assign w_out[2*c]   = w_in[3*c] ^ w_in[3*c+1] ^ w_in[3*c+2];
         assign w_out[2*c+1] = ((w_in[3*c] & w_in[3*c+1]) |
                                (w_in[3*c] & w_in[3*c+2]) |
                                (w_in[3*c+1] & w_in[3*c+2])) << 1;
      end

      for (genvar r = 0; r < N_IN - 3 * N_CSA; r++) begin : g_pass
         assign w_out[2*N_CSA+r] = w_in[3*N_CSA+r];
      end
   end

   assign w_sum2 = g_stg[N_STG-1].w_out[0];
   assign w_car2 = g_stg[N_STG-1].w_out[1];

`ifdef BOOTH_MUL_MAC_EN
   logic             r_acc1, r_acc2;
   logic [OUT_W-1:0] r_acc_q;
   assign w_p3 = r_s2 + r_c2 + (r_acc2 ? r_acc_q : '0);
`else
   assign w_p3 = r_s2 + r_c2;
`endif

   // Valid bits, result register and accumulator; everything holds on stall.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_v1    <= 1'b0;
         r_v2    <= 1'b0;
         r_v3    <= 1'b0;
         r_p     <= '0;
`ifdef BOOTH_MUL_MAC_EN
         r_acc_q <= '0;
`endif
      end else if (!w_stall) begin
         r_v1 <= in_valid;
         r_v2 <= r_v1;
         r_v3 <= r_v2;
         if (r_v2) begin
            r_p     <= w_p3;
`ifdef BOOTH_MUL_MAC_EN
            r_acc_q <= w_p3;
`endif
         end
      end
   end

   // Stage data registers carry no reset; their valid bits qualify them.
   always_ff @(posedge clk) begin
      if (!w_stall) begin
         r_a1   <= in_a;
         r_b1   <= in_b;
         r_sgn1 <= in_signed;
         r_s2   <= w_sum2;
         r_c2   <= w_car2;
`ifdef BOOTH_MUL_MAC_EN
         r_acc1 <= in_acc & in_valid;
         r_acc2 <= r_acc1;
`endif
      end
   end

endmodule

// File: tb/tb_booth_mul_pipe.sv
// Directed self-checking bench for booth_mul_pipe at WIDTH=12.
module tb_booth_mul_pipe;

   localparam int unsigned W  = 12;
   localparam int unsigned OW = 24;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic          in_signed;
   logic          out_valid;
   logic          out_ready;
   logic [OW-1:0] out_p;
`ifdef BOOTH_MUL_MAC_EN
   logic          in_acc = 1'b0;
`endif

   int checks = 0;
   int errors = 0;
   logic [OW-1:0] exp_q [$];

   typedef struct {
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic          s;
      logic [OW-1:0] p;
   } vec_t;

   vec_t vecs [10] = '{
      '{12'hFFF, 12'hFFF, 1'b0, 24'hFFE001},
      '{12'hFFF, 12'hFFF, 1'b1, 24'h000001},
      '{12'h7FF, 12'h800, 1'b1, 24'hC00800},
      '{12'h800, 12'hFFF, 1'b0, 24'h7FF800},
      '{12'h800, 12'h001, 1'b1, 24'hFFF800},
      '{12'h07B, 12'h1C8, 1'b0, 24'h00DB18},
      '{12'h000, 12'hABC, 1'b1, 24'h000000},
      '{12'hFFD, 12'h005, 1'b1, 24'hFFFFF1},
      '{12'h800, 12'h800, 1'b0, 24'h400000},
      '{12'hAAA, 12'h555, 1'b0, 24'h38DC72}
   };

   always #5 clk = ~clk;

   booth_mul_pipe #(.WIDTH(W), .OUT_W(OW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_signed (in_signed),
`ifdef BOOTH_MUL_MAC_EN
      .in_acc    (in_acc),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p     (out_p)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [OW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
      longint pa, pb;
      pa = s ? longint'($signed(a)) : longint'(a);
      pb = s ? longint'($signed(b)) : longint'(b);
      return OW'(pa * pb);
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One cycle: drive inputs, check in_ready, score any output transfer, queue any input transfer.
   task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input logic ordy, input logic [OW-1:0] exp_p);
      in_valid  = v;
      in_a      = a;
      in_b      = b;
      in_signed = s;
      out_ready = ordy;
      #1;
      check("in_ready", 64'(in_ready), 64'(!(out_valid && !ordy)));
      if (out_valid && ordy) begin
         if (exp_q.size() == 0) check("unexpected_out", 64'(out_valid), 64'd0);
         else                   check("out_p", 64'(out_p), 64'(exp_q.pop_front()));
      end
      if (v && in_ready) exp_q.push_back(exp_p);
      tick();
   endtask

   // Empty the pipe with out_ready high; 'strict' demands back-to-back results.
   task automatic drain(input bit strict);
      for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
         if (strict) check("no_bubble", 64'(out_valid), 64'd1);
         step(1'b0, '0, '0, 1'b0, 1'b1, '0);
      end
      check("drain_left", 64'(exp_q.size()), 64'd0);
      check("drain_idle", 64'(out_valid), 64'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_signed = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      tick();
      tick();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready",  64'(in_ready),  64'd1);
      check("rst_out_p",     64'(out_p),     64'd0);
      rst_n = 1'b1;
      tick();

      // Latency: signed -2048 * -2048, visible after the third edge counting the capture edge.
      in_valid = 1'b1; in_a = 12'h800; in_b = 12'h800; in_signed = 1'b1; out_ready = 1'b1;
      #1 check("lat_in_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      check("lat_c1_valid", 64'(out_valid), 64'd0);
      tick();
      check("lat_c2_valid", 64'(out_valid), 64'd0);
      tick();
      check("lat_c3_valid", 64'(out_valid), 64'd1);
      check("lat_c3_p",     64'(out_p),     64'h400000);
      tick();
      check("lat_after_valid", 64'(out_valid), 64'd0);

      // Directed corner vectors back to back, then a bubble-free drain.
      foreach (vecs[k]) step(1'b1, vecs[k].a, vecs[k].b, vecs[k].s, 1'b1, vecs[k].p);
      drain(1'b1);

      // Three transfers, five stalled cycles, then release.
      step(1'b1, 12'd100, 12'd200, 1'b0, 1'b0, 24'h004E20);
      step(1'b1, 12'hFFF, 12'd7,   1'b1, 1'b0, 24'hFFFFF9);
      step(1'b1, 12'hFFF, 12'd2,   1'b0, 1'b0, 24'h001FFE);
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", 64'(out_valid), 64'd1);
         check("stall_p",     64'(out_p),     64'h004E20);
         step(1'b1, 12'h555, 12'h001, 1'b0, 1'b0, 24'h000555);
      end
      drain(1'b1);

      // Reset with three operations in flight discards them all.
      step(1'b1, 12'd11, 12'd13, 1'b0, 1'b1, 24'd143);
      step(1'b1, 12'd17, 12'd19, 1'b0, 1'b1, 24'd323);
      step(1'b1, 12'd23, 12'd29, 1'b0, 1'b1, 24'd667);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      exp_q.delete();
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      check("midrst_out_p",    64'(out_p),    64'd0);
      for (int i = 0; i < 4; i++) begin
         check("midrst_flush", 64'(out_valid), 64'd0);
         tick();
      end
      step(1'b1, 12'd15, 12'd15, 1'b0, 1'b1, 24'd225);
      drain(1'b0);

`ifdef BOOTH_MUL_MAC_EN
      in_acc = 1'b0;
      step(1'b1, 12'd3, 12'd4, 1'b0, 1'b1, 24'd12);
      in_acc = 1'b1;
      step(1'b1, 12'd5, 12'd6, 1'b0, 1'b1, 24'd42);
      in_acc = 1'b0;
      drain(1'b0);
`endif

      // Random stream with random valid and out_ready against the reference product.
      for (int n = 0; n < 200; n++) begin
         logic [W-1:0] ra, rb;
         logic         rs, rv, ro;
         ra = W'($urandom);
         rb = W'($urandom);
         rs = 1'($urandom);
         rv = ($urandom_range(0, 3) != 0);
         ro = ($urandom_range(0, 2) != 0);
         step(rv, ra, rb, rs, ro, ref_mul(ra, rb, rs));
      end
      drain(1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/booth_mul_pipe.md
BOOTH_MUL_PIPE -- requirements
Module: booth_mul_pipe

Interface
REQ-001 Parameter WIDTH, default 12, operand width in bits; SHALL be even and in 8..32.
REQ-002 Parameter OUT_W, default 2*WIDTH, result width; SHALL be fixed at 2*WIDTH.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 in_valid  input  1  operand pair valid.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 in_a, in_b  input  WIDTH  multiplicand, multiplier.
REQ-008 in_signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 out_p  output  OUT_W  product.

Function
REQ-012 A transfer SHALL occur on a port when valid and ready are both high at a clock edge.
REQ-013 The datapath SHALL be 3 registered stages: S1 operand capture; S2 radix-4 Booth encoding, partial-product generation and Dadda reduction to 2 rows; S3 final carry-propagate add.
REQ-014 Latency SHALL be exactly 3 cycles from input transfer to out_valid when out_ready is held high.
REQ-015 Throughput SHALL be one operation per cycle with no bubbles while out_ready is high.
REQ-016 A global stall SHALL be asserted when out_valid=1 and out_ready=0; during a stall all stage registers and valid bits SHALL hold.
REQ-017 in_ready SHALL equal NOT stall; it SHALL be combinational in out_valid and out_ready only, never in in_valid.
REQ-018 Stage valid bits SHALL advance with bubbles when not stalled; an empty stage SHALL never produce out_valid.
REQ-019 Unsigned mode SHALL zero-extend operands by 2 bits before Booth recoding; signed mode SHALL sign-extend them.
REQ-020 The Booth digit count SHALL be WIDTH/2+1.
REQ-021 Sign handling SHALL use the constant sign-extension-elimination row, so no row exceeds OUT_W bits.
REQ-022 out_p SHALL equal the exact product modulo 2^OUT_W for every operand value in both modes, including the most negative value.
REQ-023 Results SHALL leave in input order; no transfer SHALL be dropped or duplicated under any valid/ready pattern.

Reset
REQ-024 While rst_n=0 at a clock edge, all stage valid bits SHALL clear, and out_valid SHALL read 0 and in_ready 1 after that edge.
REQ-025 out_p SHALL reset to 0; internal data registers need not be reset.
REQ-026 A reset asserted mid-operation SHALL discard all in-flight operations; none SHALL appear after reset.

Configuration
REQ-027 Macro BOOTH_MUL_MAC_EN SHALL, when defined, add input in_acc (1 bit, qualified by in_valid) and an OUT_W accumulator register acc_q that resets to 0.
REQ-028 With BOOTH_MUL_MAC_EN, an operation with in_acc=1 SHALL yield product + acc_q modulo 2^OUT_W, with acc_q injected as a third row in S3; in_acc=0 SHALL yield the bare product.
REQ-029 With BOOTH_MUL_MAC_EN, acc_q SHALL load the value written into the S3 output register on every S3 load.
REQ-030 Without BOOTH_MUL_MAC_EN, neither port nor register SHALL exist, and behaviour SHALL be REQ-012..026 only.

Structure
REQ-031 Package booth_mul_pkg SHALL hold the Booth digit enum (ZERO, P1, P2, M1, M2), the function computing the Dadda height sequence (2,3,4,6,9,...), and the digit-count function.
REQ-032 Sub-module booth_enc SHALL map one 3-bit overlapping multiplier window to the digit enum; it SHALL be instantiated WIDTH/2+1 times.
REQ-033 The Dadda stages SHALL be generate loops driven by the package height function, with no hand-placed adders.

Verification (WIDTH=12)
REQ-034 Signed, a=-2048, b=-2048, out_ready=1 -> out_p=0x400000 exactly 3 cycles later.
REQ-035 Unsigned, a=4095, b=4095 -> out_p=16769025 (0xFFE001); signed, same bits -> out_p=1.
REQ-036 Back-to-back stream of 200 random pairs with random out_ready -> in-order results match the reference product, and in_ready=0 exactly on stall cycles.
REQ-037 3 transfers, then out_ready=0 for 5 cycles -> out_valid held, out_p stable, in_ready=0; release -> 3 results on 3 consecutive cycles.
REQ-038 rst_n pulled low for 1 cycle with 3 operations in flight -> out_valid=0 for the following 3 cycles and no stale result.
REQ-039 BOOTH_MUL_MAC_EN: 3*4 with in_acc=0, then 5*6 with in_acc=1 -> out_p 12 then 42.
